// File: rtl/load_align_unit.sv
// Sequential load unit: issues one or two aligned bus reads per load request,
// then merges, shifts and extends the requested bytes into the response.
package common;
  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;
endpackage

module load_align_unit
  import common::*;
#(
  parameter int unsigned XLEN             = 64,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  msize_t          req_size,
  input  logic            req_unsigned,
  output logic            bus_valid,
  output logic [XLEN-1:0] bus_addr,
  input  logic            bus_ok,
  input  logic [XLEN-1:0] bus_data,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_error
);

  localparam int unsigned WB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(WB);
  localparam int unsigned PW   = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t          state;
  logic [OFFW-1:0] off_q;
  msize_t          size_q;
  logic            uns_q;
  logic            split_q;
  logic [XLEN-1:0] lo_q;

  logic [OFFW-1:0] req_off;
  int unsigned     req_nbytes;
  logic            req_split;
  logic            req_illegal;

  always_comb begin
    req_off     = req_addr[OFFW-1:0];
    req_nbytes  = 32'd1 << req_size;
    req_split   = (32'(req_off) + req_nbytes) > WB;
    req_illegal = (req_nbytes > WB) ||
                  (!SPLIT_MISALIGNED && ((32'(req_off) & (req_nbytes - 32'd1)) != 32'd0));
  end

  // Shift the {hi, lo} pair down to the requested bytes, then extend.
  function automatic logic [XLEN-1:0] merge(input logic [PW-1:0] pair,
                                            input logic [OFFW-1:0] off,
                                            input msize_t sz, input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic            sgn;
    int unsigned     nbits;
    sh    = XLEN'(pair >> {off, 3'b000});
    nbits = 32'd8 << sz;
    keep  = (XLEN'(1) << nbits) - XLEN'(1);
    case (sz)
      MSIZE1:  sgn = sh[7];
      MSIZE2:  sgn = sh[15];
      MSIZE4:  sgn = sh[31];
      default: sgn = sh[XLEN-1];
    endcase
    sgn = sgn && !uns;
    return (sh & keep) | (sgn ? ~keep : '0);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      bus_valid  <= 1'b0;
      bus_addr   <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
      off_q      <= '0;
      size_q     <= MSIZE1;
      uns_q      <= 1'b0;
      split_q    <= 1'b0;
      lo_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            off_q     <= req_off;
            size_q    <= req_size;
            uns_q     <= req_unsigned;
            split_q   <= req_split;
            if (req_illegal) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_data  <= '0;
            end else begin
              state     <= BEAT0;
              bus_valid <= 1'b1;
              bus_addr  <= req_addr & ~(XLEN'(WB) - XLEN'(1));
            end
          end
        end
        BEAT0: begin
          if (bus_ok) begin
            if (split_q) begin
              state    <= BEAT1;
              lo_q     <= bus_data;
              bus_addr <= bus_addr + XLEN'(WB);
            end else begin
              state      <= RESP;
              bus_valid  <= 1'b0;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_data  <= merge(PW'(bus_data), off_q, size_q, uns_q);
            end
          end
        end
        BEAT1: begin
          if (bus_ok) begin
            state      <= RESP;
            bus_valid  <= 1'b0;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_data  <= merge({bus_data, lo_q}, off_q, size_q, uns_q);
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: three configurations (64/split, 64/no-split,
// 32/split) driven from a directed table, a reset sequence and random loads.
module tb_load_align_unit;
  import common::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid    [3];
  logic        req_unsigned [3];
  logic        bus_ok       [3];
  logic        resp_ready   [3];
  logic [63:0] req_addr     [3];
  logic [63:0] bus_data     [3];
  msize_t      req_size     [3];
  logic        req_ready    [3];
  logic        bus_valid    [3];
  logic        resp_valid   [3];
  logic        resp_error   [3];
  logic [63:0] bus_addr     [3];
  logic [63:0] resp_data    [3];
  logic [31:0] bus_addr32, resp_data32;

  assign bus_addr[2]  = {32'b0, bus_addr32};
  assign resp_data[2] = {32'b0, resp_data32};

  load_align_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b1)) u_s64 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .bus_valid(bus_valid[0]), .bus_addr(bus_addr[0]), .bus_ok(bus_ok[0]),
    .bus_data(bus_data[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_error(resp_error[0]));

  load_align_unit #(.XLEN(64), .SPLIT_MISALIGNED(1'b0)) u_n64 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .bus_valid(bus_valid[1]), .bus_addr(bus_addr[1]), .bus_ok(bus_ok[1]),
    .bus_data(bus_data[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_error(resp_error[1]));

  load_align_unit #(.XLEN(32), .SPLIT_MISALIGNED(1'b1)) u_s32 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2][31:0]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .bus_valid(bus_valid[2]), .bus_addr(bus_addr32), .bus_ok(bus_ok[2]),
    .bus_data(bus_data[2][31:0]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_data(resp_data32), .resp_error(resp_error[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned wb_of(input int sel);
    return (sel == 2) ? 4 : 8;
  endfunction

  function automatic logic [63:0] amask(input int sel);
    return (sel == 2) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Byte-addressed memory image used for random traffic.
  function automatic logic [7:0] mb(input logic [63:0] a);
    return 8'(a[7:0] * 8'd37) ^ 8'(a[15:8] + 8'd11) ^ 8'(a[23:16] * 8'd3) ^ 8'h5A;
  endfunction

  function automatic logic [63:0] mem_word(input int sel, input logic [63:0] a);
    logic [63:0] w = '0;
    for (int i = 0; i < int'(wb_of(sel)); i++) w[8*i +: 8] = mb((a + 64'(i)) & amask(sel));
    return w;
  endfunction

  // Reference: gather bytes addr..addr+n-1 from memory, little-endian, then extend.
  task automatic ref_load(input int sel, input logic [63:0] addr, input msize_t sz,
                          input logic uns, input int bdly, output logic [63:0] d,
                          output logic e, output int beats, output int lat);
    int unsigned nb  = 1 << sz;
    int unsigned wb  = wb_of(sel);
    int unsigned off = int'(addr % 64'(wb));
    logic [63:0] v = '0;
    e = (nb > wb) || (sel == 1 && (addr % 64'(nb)) != 0);
    if (e) begin
      d = '0; beats = 0; lat = 1;
      return;
    end
    for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = mb((addr + 64'(i)) & amask(sel));
    if (!uns && v[8*nb-1])
      for (int unsigned i = 8*nb; i < 8*wb; i++) v[i] = 1'b1;
    d     = v;
    beats = (off + nb > wb) ? 2 : 1;
    lat   = beats * (bdly + 1) + 1;
  endtask

  // Drives one request, plays the bus and consumer, reports what came back.
  task automatic xact(input int sel, input logic [63:0] addr, input msize_t sz,
                      input logic uns, input bit use_mem, input logic [63:0] w0,
                      input logic [63:0] w1, input int bdly, input int rdly,
                      output logic [63:0] d, output logic e, output int beats,
                      output int lat);
    int          n, wcnt, rcnt;
    bit          consumed, done;
    int unsigned wb = wb_of(sel);
    logic [63:0] ba_exp;
    n = 0;
    while (req_ready[sel] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 64'(req_ready[sel]), 64'd1);
    req_valid[sel]    = 1'b1;
    req_addr[sel]     = addr;
    req_size[sel]     = sz;
    req_unsigned[sel] = uns;
    @(negedge clk);
    req_valid[sel] = 1'b0;
    n = 1; wcnt = 0; rcnt = 0; beats = 0; lat = 0; d = '0; e = 1'b0;
    consumed = 1'b0; done = 1'b0;
    ba_exp = addr & ~64'(wb - 1) & amask(sel);
    while (!done && n < 200) begin
      bus_ok[sel] = 1'b0;
      if (consumed) begin
        chk("req_ready_after_resp", 64'(req_ready[sel]), 64'd1);
        chk("resp_valid_dropped", 64'(resp_valid[sel]), 64'd0);
        resp_ready[sel] = 1'b0;
        done = 1'b1;
      end else begin
        chk("req_ready_busy", 64'(req_ready[sel]), 64'd0);
        if (bus_valid[sel]) begin
          chk(wcnt == 0 ? "bus_addr" : "bus_addr_stable", bus_addr[sel], ba_exp);
          if (wcnt == bdly) begin
            bus_ok[sel]   = 1'b1;
            bus_data[sel] = use_mem ? mem_word(sel, ba_exp) : (beats == 0 ? w0 : w1);
            beats++;
            wcnt   = 0;
            ba_exp = (ba_exp + 64'(wb)) & amask(sel);
          end else wcnt++;
        end else if (resp_valid[sel]) begin
          if (rcnt == 0) begin
            lat = n; d = resp_data[sel]; e = resp_error[sel];
          end else begin
            chk("resp_data_stable", resp_data[sel], d);
            chk("resp_error_stable", 64'(resp_error[sel]), 64'(e));
          end
          if (rcnt == rdly) begin
            resp_ready[sel] = 1'b1;
            consumed = 1'b1;
          end
          rcnt++;
        end
        @(negedge clk);
        n++;
      end
    end
    if (!done) begin
      chk("xact_timeout", 64'd1, 64'd0);
      bus_ok[sel] = 1'b0;
      resp_ready[sel] = 1'b0;
    end
  endtask

  typedef struct {
    int          sel;
    logic [63:0] addr;
    msize_t      sz;
    logic        uns;
    logic [63:0] w0, w1;
    int          bdly, rdly;
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_beats, exp_lat;
  } vec_t;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [63:0] d, rd;
    logic        e, re;
    int          beats, lat, rbeats, rlat;

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_unsigned[i] = 1'b0; bus_ok[i] = 1'b0;
      resp_ready[i] = 1'b0; req_addr[i] = '0; bus_data[i] = '0; req_size[i] = MSIZE1;
    end

    tbl.push_back('{0, 64'h1003, MSIZE1, 1'b0, 64'h1122_3344_8566_7788, 64'h0, 0, 0,
                    64'hFFFF_FFFF_FFFF_FF85, 1'b0, 1, 2});
    tbl.push_back('{0, 64'h2006, MSIZE4, 1'b1, 64'hAABB_0000_0000_0000, 64'hCCDD, 0, 0,
                    64'h0000_0000_CCDD_AABB, 1'b0, 2, 3});
    tbl.push_back('{1, 64'h1001, MSIZE2, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 1'b1, 0, 1});
    tbl.push_back('{1, 64'h1000, MSIZE8, 1'b0, 64'h8877_6655_4433_2211, 64'h0, 0, 0,
                    64'h8877_6655_4433_2211, 1'b0, 1, 2});
    tbl.push_back('{2, 64'h100, MSIZE8, 1'b0, 64'h0, 64'h0, 0, 0, 64'h0, 1'b1, 0, 1});
    tbl.push_back('{2, 64'hFFFF_FFFF, MSIZE2, 1'b0, 64'hAB00_0000, 64'hCD, 0, 0,
                    64'h0000_0000_FFFF_CDAB, 1'b0, 2, 3});
    tbl.push_back('{0, 64'h3004, MSIZE4, 1'b0, 64'h8000_0001_0000_0000, 64'h0, 3, 4,
                    64'hFFFF_FFFF_8000_0001, 1'b0, 1, 5});
    tbl.push_back('{0, 64'h10, MSIZE8, 1'b1, 64'hDEAD_BEEF_0123_4567, 64'h0, 1, 2,
                    64'hDEAD_BEEF_0123_4567, 1'b0, 1, 3});
    tbl.push_back('{0, 64'h17, MSIZE2, 1'b1, 64'h9900_0000_0000_0000, 64'h77, 0, 1,
                    64'h7799, 1'b0, 2, 3});
    tbl.push_back('{2, 64'h2, MSIZE4, 1'b1, 64'h4433_2211, 64'h8877_6655, 2, 0,
                    64'h6655_4433, 1'b0, 2, 7});
    tbl.push_back('{0, 64'hFFFF_FFFF_FFFF_FFFE, MSIZE4, 1'b0, 64'h1234_0000_0000_0000,
                    64'h9A78, 1, 1, 64'hFFFF_FFFF_9A78_1234, 1'b0, 2, 5});
    tbl.push_back('{1, 64'h1006, MSIZE4, 1'b1, 64'h0, 64'h0, 0, 2, 64'h0, 1'b1, 0, 1});
    tbl.push_back('{0, 64'h2002, MSIZE2, 1'b0, 64'h0000_0000_7FFE_0000, 64'h0, 0, 0,
                    64'h7FFE, 1'b0, 1, 2});
    tbl.push_back('{2, 64'h7, MSIZE1, 1'b1, 64'h8000_0000, 64'h0, 0, 0, 64'h80, 1'b0, 1, 2});
    tbl.push_back('{1, 64'h1006, MSIZE2, 1'b1, 64'hBEEF_0000_0000_0000, 64'h0, 0, 0,
                    64'hBEEF, 1'b0, 1, 2});

    // Reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_req_ready", 64'(req_ready[i]), 64'd0);
      chk("rst_bus_valid", 64'(bus_valid[i]), 64'd0);
      chk("rst_bus_addr", bus_addr[i], 64'd0);
      chk("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
      chk("rst_resp_data", resp_data[i], 64'd0);
      chk("rst_resp_error", 64'(resp_error[i]), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("post_rst_req_ready", 64'(req_ready[i]), 64'd1);

    // Directed table
    foreach (tbl[k]) begin
      xact(tbl[k].sel, tbl[k].addr, tbl[k].sz, tbl[k].uns, 1'b0, tbl[k].w0, tbl[k].w1,
           tbl[k].bdly, tbl[k].rdly, d, e, beats, lat);
      chk($sformatf("tbl%0d_data", k), d, tbl[k].exp_d);
      chk($sformatf("tbl%0d_error", k), 64'(e), 64'(tbl[k].exp_e));
      chk($sformatf("tbl%0d_beats", k), 64'(beats), 64'(tbl[k].exp_beats));
      chk($sformatf("tbl%0d_latency", k), 64'(lat), 64'(tbl[k].exp_lat));
    end

    // Reset while waiting on the second beat of a split load
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 64'h2006; req_size[0] = MSIZE4; req_unsigned[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("rstseq_beat0_valid", 64'(bus_valid[0]), 64'd1);
    bus_ok[0] = 1'b1; bus_data[0] = 64'hAABB_0000_0000_0000;
    @(negedge clk);
    bus_ok[0] = 1'b0;
    chk("rstseq_beat1_valid", 64'(bus_valid[0]), 64'd1);
    chk("rstseq_beat1_addr", bus_addr[0], 64'h2008);
    #2 reset = 1'b0;
    #1;
    chk("rstseq_bus_valid_async", 64'(bus_valid[0]), 64'd0);
    chk("rstseq_resp_valid_async", 64'(resp_valid[0]), 64'd0);
    chk("rstseq_req_ready_async", 64'(req_ready[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bus_ok[0] = 1'b1; bus_data[0] = 64'h0000_0000_0000_CCDD;
    @(negedge clk);
    bus_ok[0] = 1'b0;
    chk("rstseq_stray_bus_valid", 64'(bus_valid[0]), 64'd0);
    chk("rstseq_stray_resp_valid", 64'(resp_valid[0]), 64'd0);
    chk("rstseq_stray_req_ready", 64'(req_ready[0]), 64'd1);
    @(negedge clk);
    chk("rstseq_stray_resp_valid2", 64'(resp_valid[0]), 64'd0);
    xact(0, 64'h2006, MSIZE4, 1'b1, 1'b0, 64'hAABB_0000_0000_0000, 64'hCCDD, 0, 0,
         d, e, beats, lat);
    chk("rstseq_after_data", d, 64'h0000_0000_CCDD_AABB);
    chk("rstseq_after_error", 64'(e), 64'd0);
    chk("rstseq_after_beats", 64'(beats), 64'd2);
    chk("rstseq_after_latency", 64'(lat), 64'd3);

    // Random loads against the byte-level memory model
    for (int it = 0; it < 300; it++) begin
      int          sel  = int'($urandom_range(0, 2));
      int          bdly = int'($urandom_range(0, 2));
      int          rdly = int'($urandom_range(0, 2));
      msize_t      sz   = msize_t'($urandom_range(0, 3));
      logic        uns  = 1'($urandom_range(0, 1));
      logic [63:0] addr;
      addr = (sel == 2) ? {32'b0, $urandom} : {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) addr = amask(sel) - 64'($urandom_range(0, 6));
      ref_load(sel, addr, sz, uns, bdly, rd, re, rbeats, rlat);
      xact(sel, addr, sz, uns, 1'b1, 64'h0, 64'h0, bdly, rdly, d, e, beats, lat);
      chk($sformatf("rnd%0d_data", it), d, rd);
      chk($sformatf("rnd%0d_error", it), 64'(e), 64'(re));
      chk($sformatf("rnd%0d_beats", it), 64'(beats), 64'(rbeats));
      chk($sformatf("rnd%0d_latency", it), 64'(lat), 64'(rlat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
